memory_stage: RTL and testbench

//   Pipeline MEM stage, directly downstream of the execute stage. Holds the word-addressed

---
 rtl/memory_stage.sv | 93 +++++++++
 tb/tb_memory_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Pipeline MEM stage: word-addressed data memory with combinational load and
// clocked store, plus the MEM/WB boundary registers feeding writeback.
module memory_stage #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPlus4W,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW
);

    // No valid/ready handshake: the pipeline never stalls, so every rising
    // edge out of reset advances the stage unconditionally.

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       read_data_m;

    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] read_data_q,  read_data_d;
    logic [4:0]  rd_q,         rd_d;
    logic [31:0] pc_plus4_q,   pc_plus4_d;
    logic        reg_write_q,  reg_write_d;
    logic [1:0]  result_src_q, result_src_d;

    // Byte-offset bits and bits above the array size are dropped, so
    // misaligned addresses round down and addresses wrap.
    assign word_idx    = ALUResultM[ADDR_W+1:2];
    assign read_data_m = mem_q[word_idx];

    always_comb begin
        mem_d = mem_q;
        if (MemWriteM) begin
            mem_d[word_idx] = WriteDataM;
        end
    end

    // Load data is taken from mem_q, so a same-cycle store to the same word
    // hands the old word to writeback.
    always_comb begin
        alu_result_d = ALUResultM;
        read_data_d  = read_data_m;
        rd_d         = RdM;
        pc_plus4_d   = PCPlus4M;
        reg_write_d  = RegWriteM;
        result_src_d = ResultSrcM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            alu_result_q <= '0;
            read_data_q  <= '0;
            rd_q         <= '0;
            pc_plus4_q   <= '0;
            reg_write_q  <= 1'b0;
            result_src_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
            rd_q         <= rd_d;
            pc_plus4_q   <= pc_plus4_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
        end
    end

    assign ALUResultW = alu_result_q;
    assign ReadDataW  = read_data_q;
    assign RdW        = rd_q;
    assign PCPlus4W   = pc_plus4_q;
    assign RegWriteW  = reg_write_q;
    assign ResultSrcW = result_src_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, reset corner
// sequences and random traffic checked against a word-array reference model.
module tb_memory_stage;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_q[$];

    memory_stage dut (
        .clk(clk), .rst(rst),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
        .PCPlus4M(PCPlus4M), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW),
        .PCPlus4W(PCPlus4W), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic [31:0] e_rdata;
    } vec_t;

    // ---------------- model / checks ----------------
    function automatic int word_of(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        exp_q.delete();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ALUResultW"}, ALUResultW, 32'h0);
        chk({tag, ".ReadDataW"},  ReadDataW,  32'h0);
        chk({tag, ".RdW"},        {27'h0, RdW}, 32'h0);
        chk({tag, ".PCPlus4W"},   PCPlus4W,   32'h0);
        chk({tag, ".RegWriteW"},  {31'h0, RegWriteW}, 32'h0);
        chk({tag, ".ResultSrcW"}, {30'h0, ResultSrcW}, 32'h0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] pc, input logic rw, input logic [1:0] rs,
                         input logic mw);
        ALUResultM = alu; WriteDataM = wd; RdM = rd; PCPlus4M = pc;
        RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw;
    endtask

    task automatic drive_random(input logic allow_store);
        logic [31:0] a;
        a = $urandom;
        a[7:2] = 6'($urandom_range(0, 7));   // few words -> frequent read-after-write hits
        drive(a, $urandom, 5'($urandom), $urandom, 1'($urandom),
              2'($urandom_range(0, 2)), allow_store ? 1'($urandom) : 1'b0);
    endtask

    // One clock with the current inputs. Expected carried fields come from the
    // inputs; expected load data is passed in (from a table or the model).
    task automatic step(input string tag, input logic [31:0] e_rdata);
        logic [31:0] e_alu, e_pc, got;
        logic [4:0]  e_rd;
        logic        e_rw;
        logic [1:0]  e_rs;
        e_alu = ALUResultM; e_pc = PCPlus4M; e_rd = RdM; e_rw = RegWriteM; e_rs = ResultSrcM;
        exp_q.push_back(e_rdata);
        @(posedge clk);
        if (MemWriteM) ref_mem[word_of(ALUResultM)] = WriteDataM;
        #1;
        got = exp_q.pop_front();
        chk({tag, ".ReadDataW"},  ReadDataW,  got);
        chk({tag, ".ALUResultW"}, ALUResultW, e_alu);
        chk({tag, ".RdW"},        {27'h0, RdW}, {27'h0, e_rd});
        chk({tag, ".PCPlus4W"},   PCPlus4W,   e_pc);
        chk({tag, ".RegWriteW"},  {31'h0, RegWriteW}, {31'h0, e_rw});
        chk({tag, ".ResultSrcW"}, {30'h0, ResultSrcW}, {30'h0, e_rs});
    endtask

    task automatic step_model(input string tag);
        step(tag, ref_mem[word_of(ALUResultM)]);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl [13];

    initial begin
        rst = 1'b1;
        model_reset();
        drive(32'h0, 32'h0, 5'h0, 32'h0, 1'b0, 2'b00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;

        // Reset asserted mid-cycle with random inputs in flight.
        for (int i = 0; i < 6; i++) begin
            drive_random(1'b1);
            step_model("pre_reset");
        end
        drive_random(1'b1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        #1;
        chk_all_zero("reset_held");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive($urandom, $urandom, 5'($urandom), $urandom, 1'($urandom), 2'b01, 1'b0);
            step("load_after_reset", 32'h0);
        end

        // Directed table, starting from a cleared memory.
        tbl[0]  = '{32'h10,  32'hDEADBEEF, 5'd1,  32'h4,   1'b0, 2'b00, 1'b1, 32'h0};
        tbl[1]  = '{32'h10,  32'h0,        5'd2,  32'h8,   1'b1, 2'b01, 1'b0, 32'hDEADBEEF};
        tbl[2]  = '{32'h10,  32'h11111111, 5'd3,  32'hC,   1'b0, 2'b00, 1'b1, 32'hDEADBEEF};
        tbl[3]  = '{32'h10,  32'h22222222, 5'd4,  32'h10,  1'b0, 2'b01, 1'b1, 32'h11111111};
        tbl[4]  = '{32'h10,  32'h0,        5'd5,  32'h14,  1'b1, 2'b01, 1'b0, 32'h22222222};
        tbl[5]  = '{32'h13,  32'hCAFEF00D, 5'd6,  32'h18,  1'b0, 2'b00, 1'b1, 32'h22222222};
        tbl[6]  = '{32'h10,  32'h0,        5'd8,  32'h1C,  1'b1, 2'b01, 1'b0, 32'hCAFEF00D};
        tbl[7]  = '{32'h110, 32'h0,        5'd9,  32'h20,  1'b1, 2'b01, 1'b0, 32'hCAFEF00D};
        tbl[8]  = '{32'h55,  32'h0,        5'd7,  32'h104, 1'b1, 2'b10, 1'b0, 32'h0};
        tbl[9]  = '{32'h54,  32'h0,        5'd10, 32'h108, 1'b1, 2'b01, 1'b0, 32'h0};
        tbl[10] = '{32'hFC,  32'hA5A5A5A5, 5'd31, 32'h10C, 1'b1, 2'b00, 1'b1, 32'h0};
        tbl[11] = '{32'hFC,  32'h0,        5'd0,  32'h110, 1'b0, 2'b01, 1'b0, 32'hA5A5A5A5};
        tbl[12] = '{32'hFFFF_FFFF, 32'h0,  5'd12, 32'h114, 1'b1, 2'b01, 1'b0, 32'hA5A5A5A5};
        reset_pulse();
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].alu, tbl[i].wd, tbl[i].rd, tbl[i].pc, tbl[i].rw, tbl[i].rs, tbl[i].mw);
            step($sformatf("tbl%0d", i), tbl[i].e_rdata);
        end

        // Reset during a store: the store is lost and memory reads back zero.
        drive(32'h20, 32'h12345678, 5'd1, 32'h0, 1'b0, 2'b00, 1'b1);
        step_model("prestore_20");
        drive(32'h20, 32'h99999999, 5'd1, 32'h0, 1'b0, 2'b00, 1'b1);
        #2;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h24, 32'h77777777, 5'd2, 32'h4, 1'b0, 2'b00, 1'b1);
        step("first_store_after_reset", 32'h0);
        drive(32'h20, 32'h0, 5'd3, 32'h8, 1'b1, 2'b01, 1'b0);
        step("mem8_after_reset", 32'h0);
        drive(32'h24, 32'h0, 5'd4, 32'hC, 1'b1, 2'b01, 1'b0);
        step("mem9_after_reset", 32'h77777777);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive_random(1'b1);
            step_model("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
